btn_input_frontend: RTL and testbench
=====================================

// Module: btn_input_frontend
// PURPOSE
// - Conditions the raw push-buttons and slide switches feeding text_screen_gen.
// - Per button: 2-flop synchroniser, debounce FSM, one-cycle press tick, optional auto-repeat.
// - Switches: 2-flop synchroniser only.
// - Runs on the 50 MHz system clock. Outputs go straight to the text screen generator's
//   cursor/write logic, replacing its raw btn_* and sw inputs.
// PARAMETERS
// - N_BTN       5           number of buttons; bit map [0]=set [1]=up [2]=down [3]=right [4]=left
// - N_SW        7           number of switches (character code)
// - DB_CYCLES   1_000_000   stable cycles before a level change is accepted (20 ms @ 50 MHz); >=2
// - RPT_DELAY   25_000_000  cycles held in ONE before the first repeat tick (500 ms); >=1
// - RPT_PERIOD  5_000_000   cycles between subsequent repeat ticks (100 ms); >=1
// - RPT_MASK    5'b11110    1 = button auto-repeats (arrows); btn_set never repeats by default
// PORTS
// - clk        in   1      system clock, all logic on rising edge
// - reset      in   1      synchronous, active-high
// - btn_in     in   N_BTN  raw asynchronous buttons, active-high
// - sw_in      in   N_SW   raw asynchronous switches
// - btn_level  out  N_BTN  debounced button level
// - btn_tick   out  N_BTN  one-cycle pulse per accepted press or repeat
// - sw_sync    out  N_SW   synchronised switches
// BEHAVIOUR
// - Reset: all sync flops, btn_level, btn_tick, sw_sync = 0; every FSM in ZERO; counters = 0.
//   Reset asserted mid-operation aborts any wait and suppresses every pending tick.
// - Sync: s = btn_in delayed 2 clocks; sw_sync = sw_in delayed 2 clocks. No further filtering on switches.
// - Debounce FSM per button, states ZERO / WAIT1 / ONE / WAIT0:
//   ZERO : s=1 -> WAIT1, load db_cnt = DB_CYCLES-1.
//   WAIT1: s=0 -> ZERO (glitch rejected, no tick).
//          db_cnt=0 -> ONE; assert tick the same edge; load rpt_cnt = RPT_DELAY-1.
//          else db_cnt--.
//   ONE  : s=0 -> WAIT0, load db_cnt = DB_CYCLES-1; rpt_cnt frozen.
//          else if RPT_MASK[i] and rpt_cnt=0 -> tick, reload rpt_cnt = RPT_PERIOD-1.
//          else if RPT_MASK[i] -> rpt_cnt--.
//   WAIT0: s=1 -> ONE; bounce; no press tick; rpt_cnt resumes from its frozen value.
//          db_cnt=0 -> ZERO (release accepted). else db_cnt--.
// - btn_level = 1 in ONE and WAIT0; registered, so it changes on the same edge as the state.
// - Latency: btn_in rises and stays high -> btn_tick and btn_level rise on the DB_CYCLES+3rd
//   rising edge after the first edge sampling btn_in=1.
//   Release latency is the same: btn_level falls, no tick.
// - Repeat: first repeat tick RPT_DELAY cycles after the press tick, then every RPT_PERIOD
//   while in ONE.
// - btn_tick is high for exactly one cycle per event. Ticks of different buttons are
//   independent and may coincide.
// - Counter widths: $clog2(max(DB_CYCLES,RPT_DELAY,RPT_PERIOD)+1). Counters load/compare only,
//   so no wrap.
// STRUCTURE
// - Shared package/header: debounce state encoding (2 bits: ZERO=0 WAIT1=1 ONE=2 WAIT0=3)
//   and button bit-index constants (BTN_SET..BTN_LEFT), also used by text_screen_gen.
// - Sub-module db_repeat_fsm: one button (sync pair + FSM + db_cnt + rpt_cnt), with
//   parameters DB_CYCLES, RPT_DELAY, RPT_PERIOD, RPT_EN.
//   Instantiated N_BTN times via generate, RPT_EN=RPT_MASK[i].
// - Top level holds only that generate loop and the switch synchroniser.
// TESTING (DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=8)
// - Clean press of up held 10 cycles -> btn_tick[1] one pulse on edge 7; btn_level[1]=1
//   from edge 7; release -> level falls 7 edges later, no tick.
// - Glitch: btn_in[0] high 3 cycles -> no tick, btn_level stays 0, FSM back in ZERO.
// - Hold right 60 cycles -> ticks at edges 7, 27, 35, 43, 51, 59.
//   Hold set 60 cycles -> only the tick at edge 7.
// - Release bounce: during hold, btn_in low 2 cycles then high -> btn_level stays 1,
//   no extra press tick, repeat schedule shifted by the 2 frozen cycles.
// - Reset asserted while up is in WAIT1 and right is in ONE -> next edge: all outputs 0.
//   After reset release with buttons still held -> new press ticks after DB_CYCLES+3.
// - Switches: sw_in=7'h41 -> sw_sync=7'h41 exactly 2 edges later.
//   up and down pressed same cycle -> btn_tick[1] and btn_tick[2] on the same edge.

Source files
------------

// File: rtl/btn_input_frontend_pkg.sv
// Shared definitions for the button/switch input front end.
// - db_state_e : debounce state encoding (also decoded by text_screen_gen)
// - BTN_*      : bit index of each push-button in btn_in/btn_level/btn_tick
// - cnt_width  : counter width able to hold the largest load value
package btn_input_frontend_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  localparam int unsigned BTN_SET   = 0;
  localparam int unsigned BTN_UP    = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_LEFT  = 4;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_input_frontend_if.sv
// Signal bundle between the raw board inputs and text_screen_gen.
// - btn_in    : raw asynchronous push-buttons, active-high
// - sw_in     : raw asynchronous slide switches
// - btn_level : debounced button level
// - btn_tick  : one-cycle pulse per accepted press or auto-repeat
// - sw_sync   : synchronised switches
// master drives the raw inputs, slave is the front end itself.
interface btn_input_frontend_if
  import btn_input_frontend_pkg::*;
#(
  parameter int unsigned N_BTN = 5,
  parameter int unsigned N_SW  = 7
);
  logic [N_BTN-1:0] btn_in;
  logic [N_SW-1:0]  sw_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_tick;
  logic [N_SW-1:0]  sw_sync;

  modport master (
    output btn_in,
    output sw_in,
    input  btn_level,
    input  btn_tick,
    input  sw_sync
  );

  modport slave (
    input  btn_in,
    input  sw_in,
    output btn_level,
    output btn_tick,
    output sw_sync
  );
endinterface

// File: rtl/btn_input_frontend_db_repeat_fsm.sv
// One push-button: 2-flop synchroniser, debounce FSM and auto-repeat.
// - clk, reset : system clock, synchronous active-high reset
// - btn_raw    : raw asynchronous button input
// - level      : debounced level (high in ONE and WAIT0)
// - tick       : one-cycle pulse on accepted press and on each repeat
module btn_input_frontend_db_repeat_fsm
  import btn_input_frontend_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned RPT_DELAY  = 25_000_000,
  parameter int unsigned RPT_PERIOD = 5_000_000,
  parameter bit          RPT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic tick
);
  localparam int unsigned CW = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
  localparam logic [CW-1:0] DB_LOAD    = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LOAD   = CW'(RPT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [1:0]    sync_q;
  logic          s;
  db_state_e     state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rpt_cnt;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state   <= ZERO;
      db_cnt  <= '0;
      rpt_cnt <= '0;
      level   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      tick   <= 1'b0;
      case (state)
        ZERO: begin
          if (s) begin
            state  <= WAIT1;
            db_cnt <= DB_LOAD;
          end
        end
        WAIT1: begin
          if (!s) begin
            state <= ZERO;
          end else if (db_cnt == '0) begin
            state   <= ONE;
            level   <= 1'b1;
            tick    <= 1'b1;
            rpt_cnt <= DELAY_LOAD;
          end else begin
            db_cnt <= db_cnt - CNT_ONE;
          end
        end
        ONE, WAIT0: begin
          // ONE and WAIT0 share the s=1 path: a bounce back from WAIT0
          // re-enters ONE and resumes the repeat count on that same edge.
          if (!s) begin
            if (state == ONE) begin
              state  <= WAIT0;
              db_cnt <= DB_LOAD;
            end else if (db_cnt == '0) begin
              state <= ZERO;
              level <= 1'b0;
            end else begin
              db_cnt <= db_cnt - CNT_ONE;
            end
          end else begin
            state <= ONE;
            if (RPT_EN) begin
              if (rpt_cnt == '0) begin
                tick    <= 1'b1;
                rpt_cnt <= PER_LOAD;
              end else begin
                rpt_cnt <= rpt_cnt - CNT_ONE;
              end
            end
          end
        end
        default: state <= ZERO;
      endcase
    end
  end

endmodule

// File: rtl/btn_input_frontend.sv
// Input conditioning for text_screen_gen.
// - clk, reset : 50 MHz system clock, synchronous active-high reset
// - bus        : slave side of btn_input_frontend_if
//                (btn_in/sw_in in; btn_level/btn_tick/sw_sync out)
// Each button gets its own debounce/repeat FSM; switches are only synchronised.
module btn_input_frontend
  import btn_input_frontend_pkg::*;
#(
  parameter int unsigned      N_BTN      = 5,
  parameter int unsigned      N_SW       = 7,
  parameter int unsigned      DB_CYCLES  = 1_000_000,
  parameter int unsigned      RPT_DELAY  = 25_000_000,
  parameter int unsigned      RPT_PERIOD = 5_000_000,
  parameter logic [N_BTN-1:0] RPT_MASK   = N_BTN'(5'b11110)
) (
  input logic                clk,
  input logic                reset,
  btn_input_frontend_if.slave bus
);
  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] tick_w;
  logic [N_SW-1:0]  sw_meta;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_input_frontend_db_repeat_fsm #(
      .DB_CYCLES (DB_CYCLES),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD),
      .RPT_EN    (RPT_MASK[i])
    ) u_fsm (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(bus.btn_in[i]),
      .level  (level_w[i]),
      .tick   (tick_w[i])
    );
  end

  assign bus.btn_level = level_w;
  assign bus.btn_tick  = tick_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta     <= '0;
      bus.sw_sync <= '0;
    end else begin
      sw_meta     <= bus.sw_in;
      bus.sw_sync <= sw_meta;
    end
  end

endmodule

// File: tb/tb_btn_input_frontend.sv
module tb_btn_input_frontend;
  import btn_input_frontend_pkg::*;

  localparam int unsigned NB = 5;
  localparam int unsigned NS = 7;
  localparam int          DB = 4;
  localparam int          RD = 20;
  localparam int          RP = 8;
  localparam logic [NB-1:0] MASK = 5'b11110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  btn_input_frontend_if #(.N_BTN(NB), .N_SW(NS)) bus ();

  btn_input_frontend #(
    .N_BTN(NB), .N_SW(NS), .DB_CYCLES(DB), .RPT_DELAY(RD),
    .RPT_PERIOD(RP), .RPT_MASK(MASK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for DB+1 consecutive edges; repeats are scheduled by counting the
  // edges since the press on which input and level are both high.
  logic [NB-1:0] m_q1 = '0, m_q2 = '0, m_lvl = '0, m_tick = '0;
  logic [NS-1:0] m_sw1 = '0, m_sw = '0;
  int            run[NB];
  int            held[NB];

  task automatic model_step();
    logic s;
    if (reset) begin
      m_q1 = '0; m_q2 = '0; m_lvl = '0; m_tick = '0; m_sw1 = '0; m_sw = '0;
      for (int i = 0; i < NB; i++) begin run[i] = 0; held[i] = 0; end
    end else begin
      for (int i = 0; i < NB; i++) begin
        s = m_q2[i];
        m_tick[i] = 1'b0;
        if (s != m_lvl[i]) begin
          run[i]++;
          if (run[i] == DB + 1) begin
            m_lvl[i] = s;
            run[i] = 0;
            if (s) begin m_tick[i] = 1'b1; held[i] = 0; end
          end
        end else begin
          run[i] = 0;
          if (s && MASK[i]) begin
            held[i]++;
            if (held[i] >= RD && ((held[i] - RD) % RP) == 0) m_tick[i] = 1'b1;
          end
        end
      end
      m_q2 = m_q1; m_q1 = bus.btn_in;
      m_sw = m_sw1; m_sw1 = bus.sw_in;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_level", int'(bus.btn_level), int'(m_lvl));
    check("model_tick", int'(bus.btn_tick), int'(m_tick));
    check("model_sw", int'(bus.sw_sync), int'(m_sw));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.btn_in = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    string name;
    int    bit_i;
    int    hold;
    int    n_ticks;
    int    first_tick;
    int    last_tick;
    int    rise;
    int    fall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, last, rise, fall, others, b, t1, t3, lo_cnt, tick_val, tick_edge;
    logic prev;
    int tq[$];
    int exp_b[5];

    bus.btn_in = '0;
    bus.sw_in = '0;

    // Reset state
    do_reset();
    check("reset_level", int'(bus.btn_level), 0);
    check("reset_tick", int'(bus.btn_tick), 0);
    check("reset_sw", int'(bus.sw_sync), 0);

    // Table-driven single-button presses; edge 1 samples btn_in=1
    vecs[0] = '{"up_clean",  BTN_UP,    10, 1, 7, 7,  7, 17};
    vecs[1] = '{"set_glitch", BTN_SET,   3, 0, -1, -1, -1, -1};
    vecs[2] = '{"right_hold", BTN_RIGHT, 60, 6, 7, 59, 7, 67};
    vecs[3] = '{"set_hold",  BTN_SET,   60, 1, 7, 7,  7, 67};
    for (int r = 0; r < 4; r++) begin
      do_reset();
      repeat (3) cycle();
      b = vecs[r].bit_i;
      n = 0; first = -1; last = -1; rise = -1; fall = -1; others = 0; prev = 1'b0;
      bus.btn_in[b] = 1'b1;
      for (int e = 1; e <= vecs[r].hold + 20; e++) begin
        cycle();
        if (bus.btn_tick[b]) begin
          n++;
          if (first < 0) first = e;
          last = e;
        end
        for (int k = 0; k < NB; k++)
          if (k != b && bus.btn_tick[k]) others++;
        if (bus.btn_level[b] && !prev) rise = e;
        if (!bus.btn_level[b] && prev) fall = e;
        prev = bus.btn_level[b];
        if (e == vecs[r].hold) bus.btn_in = '0;
      end
      check({vecs[r].name, "_nticks"}, n, vecs[r].n_ticks);
      check({vecs[r].name, "_first"}, first, vecs[r].first_tick);
      check({vecs[r].name, "_last"}, last, vecs[r].last_tick);
      check({vecs[r].name, "_rise"}, rise, vecs[r].rise);
      check({vecs[r].name, "_fall"}, fall, vecs[r].fall);
      check({vecs[r].name, "_others"}, others, 0);
    end

    // Release bounce: low for 2 samples mid-hold, repeat schedule slips by 2
    do_reset();
    repeat (3) cycle();
    exp_b[0] = 7; exp_b[1] = 27; exp_b[2] = 37; exp_b[3] = 45; exp_b[4] = 53;
    tq.delete();
    lo_cnt = 0; fall = -1; prev = 1'b0;
    bus.btn_in[BTN_RIGHT] = 1'b1;
    for (int e = 1; e <= 75; e++) begin
      cycle();
      if (bus.btn_tick[BTN_RIGHT]) tq.push_back(e);
      if (e >= 7 && e <= 62 && !bus.btn_level[BTN_RIGHT]) lo_cnt++;
      if (!bus.btn_level[BTN_RIGHT] && prev) fall = e;
      prev = bus.btn_level[BTN_RIGHT];
      if (e == 30) bus.btn_in[BTN_RIGHT] = 1'b0;
      if (e == 32) bus.btn_in[BTN_RIGHT] = 1'b1;
      if (e == 56) bus.btn_in[BTN_RIGHT] = 1'b0;
    end
    check("bounce_level_drop", lo_cnt, 0);
    check("bounce_fall", fall, 63);
    check("bounce_nticks", tq.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bounce_tick%0d", i), (i < tq.size()) ? tq[i] : -1, exp_b[i]);

    // Reset with up in WAIT1 and right in ONE
    do_reset();
    bus.sw_in = 7'h55;
    repeat (3) cycle();
    bus.btn_in[BTN_RIGHT] = 1'b1;
    repeat (10) cycle();
    bus.btn_in[BTN_UP] = 1'b1;
    repeat (4) cycle();
    check("pre_reset_right_level", int'(bus.btn_level[BTN_RIGHT]), 1);
    check("pre_reset_sw", int'(bus.sw_sync), 'h55);
    reset = 1'b1;
    cycle();
    check("midreset_level", int'(bus.btn_level), 0);
    check("midreset_tick", int'(bus.btn_tick), 0);
    check("midreset_sw", int'(bus.sw_sync), 0);
    reset = 1'b0;
    t1 = -1; t3 = -1;
    for (int e = 1; e <= 30; e++) begin
      cycle();
      if (bus.btn_tick[BTN_UP] && t1 < 0) t1 = e;
      if (bus.btn_tick[BTN_RIGHT] && t3 < 0) t3 = e;
    end
    check("postreset_up_tick", t1, DB + 3);
    check("postreset_right_tick", t3, DB + 3);
    bus.btn_in = '0;
    bus.sw_in = '0;

    // Switch synchroniser: exactly two edges of latency
    do_reset();
    cycle();
    bus.sw_in = 7'h41;
    cycle();
    check("sw_edge1", int'(bus.sw_sync), 0);
    cycle();
    check("sw_edge2", int'(bus.sw_sync), 'h41);

    // Up and down pressed together tick on the same edge
    do_reset();
    repeat (3) cycle();
    bus.btn_in = 5'b00110;
    tick_edge = -1; tick_val = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (tick_edge < 0 && bus.btn_tick != '0) begin
        tick_edge = e;
        tick_val = int'(bus.btn_tick);
      end
    end
    check("dual_tick_edge", tick_edge, 7);
    check("dual_tick_val", tick_val, 'b00110);
    bus.btn_in = '0;
    repeat (12) cycle();

    // Randomised run against the reference model
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < NB; i++)
          if ($urandom_range(0, (seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 12 : 45) == 0)
            bus.btn_in[i] = ~bus.btn_in[i];
        if ($urandom_range(0, 7) == 0) bus.sw_in = NS'($urandom);
        reset = ($urandom_range(0, 299) == 0);
        cycle();
      end
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
